seven_seg_scan: RTL
===================

# seven_seg_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display, the multi-digit successor to the single-digit hex decoder. It holds a shadow copy of a packed hex value, scans digits one at a time with a programmable dwell and an anti-ghosting guard, and supports optional leading-zero blanking and per-digit decimal points. It sits between any value-producing logic and the board's `an`/`seg`/`dp` pins.

## Interface
- `NUM_DIGITS`, default 4: digits scanned; legal range 1..8.
- `TICKS_PER_DIGIT`, default 100000: clock cycles per digit slot; 1 ms at 100 MHz.
- `GUARD_TICKS`, default 1000: cycles at the start of each slot with all anodes off; must be less than `TICKS_PER_DIGIT`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `load` in 1: when high, capture `value` and `dp_in` into the shadow registers.
- `value` in 4*NUM_DIGITS: packed hex nibbles; nibble i, bits [4i+3:4i], drives digit i; digit 0 is rightmost.
- `dp_in` in NUM_DIGITS: decimal point request per digit, active-high.
- `blank_lz` in 1: enable leading-zero blanking.
- `anodes` out NUM_DIGITS: digit enables, active-low.
- `segments` out 7: active-low; bit0=a … bit6=g.
- `dp_n` out 1: decimal point, active-low.

## Operation
- Shadow registers `val_q` and `dp_q` reset to 0 and load on any cycle with `load`=1. The display never reads `value` directly, so there is no tearing mid-scan.
- Prescaler `tick_cnt` counts 0..TICKS_PER_DIGIT-1 and then wraps to 0. At the wrap, `digit_idx` increments, and wraps from NUM_DIGITS-1 to 0.
- Slot phase:
  - `tick_cnt` < GUARD_TICKS is the guard phase. All anodes are 1, `segments` is 7'h7F and `dp_n` is 1.
  - Otherwise the slot is active. Only `anodes[digit_idx]` is 0.
- Active slot content:
  - `segments` is the hex decode of `val_q` nibble `digit_idx` (0-F; A-F use the standard b, C, d, E, F glyphs).
  - `dp_n` is the inverse of `dp_q[digit_idx]`.
- Leading-zero blanking applies when `blank_lz`=1 and digit i>0. If nibble i and all higher nibbles are 0, `segments` becomes 7'h7F.
  - The anode is still driven and `dp_n` is still honoured.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- `load` during any phase takes effect from the next output update. The current slot content changes mid-slot; this is accepted.
- Reset mid-scan returns the block to the reset state on the next edge: counters 0, shadows 0, outputs off.

## Timing
- All outputs are registered, with 1 cycle latency from (`tick_cnt`, `digit_idx`, `val_q`).
- Output reset values: `anodes`=all 1, `segments`=7'h7F, `dp_n`=1.
- After `reset` deasserts:
  - Cycle 0 is the first counted cycle.
  - Digit 0 anode goes low at the edge ending cycle GUARD_TICKS.
  - It stays low for TICKS_PER_DIGIT-GUARD_TICKS cycles.
- Full frame = NUM_DIGITS*TICKS_PER_DIGIT cycles.
- Exactly one anode is ever low, never two. Adjacent active windows are separated by at least GUARD_TICKS cycles with all anodes high.
- From `load`: shadow updates at edge t+1, and outputs reflect the new value at edge t+2 if the slot is active.

## Configuration
- `SEVENSEG_PWM_EN` defined:
  - Adds input port `brightness` [3:0] and a free-running 4-bit `pwm_cnt`, reset 0, incremented every cycle.
  - During the active phase the anode is low only when `pwm_cnt` <= `brightness`. `brightness`=15 gives full on; 0 gives 1/16 duty.
  - `segments`/`dp_n` still follow the active-slot rules.
- Not defined: the port and counter are absent, and the active phase is always fully lit.

## Structure
- Package `seven_seg_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - 16-entry active-low glyph constant array.
  - Typedef `seg_t` = logic [6:0].
- Sub-module `seven_seg_decode`: combinational, 4-bit nibble → `seg_t`, using the package table. It is instantiated once on the muxed nibble.
- The prescaler, scan index, shadows, blanking logic and output registers live in `seven_seg_scan`.
- Counter widths use $clog2 of the respective parameter.

## Test plan
Bench parameters: NUM_DIGITS=4, TICKS_PER_DIGIT=8, GUARD_TICKS=2.
- Reset: hold `reset` 3 cycles → `anodes`=4'b1111, `segments`=7'h7F, `dp_n`=1 throughout.
- Scan order: load `value`=16'h1234, `blank_lz`=0 → per 32-cycle frame:
  - Each of `anodes`=1110, 1101, 1011, 0111 is low for 6 cycles.
  - `segments` is the glyph of 4, 3, 2, 1 respectively.
  - Each active window is followed by 2 all-off cycles.
- Blanking: `value`=16'h0050, `blank_lz`=1 → digits 3 and 2 show 7'h7F, digit 1 shows "5", digit 0 shows "0". With `value`=0, only digit 0 shows "0".
- Decimal point: `dp_in`=4'b0100 → `dp_n`=0 only while `anodes`=1011.
- Load timing: assert `load` with `value`=16'hFFFF mid-slot of digit 2 → that digit's `segments` switches to the "F" glyph 2 cycles later; scan timing is unaffected.
- PWM (`SEVENSEG_PWM_EN`): `brightness`=3 → within the active window the anode is low exactly when `pwm_cnt` is 0-3; `brightness`=15 → continuously low.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and constants for the seven-segment scan driver.
//   seg_t      - one digit's segment bus, active-low, bit0=a .. bit6=g
//   SEG_BLANK  - all segments off
//   SEG_GLYPH  - active-low glyphs for hex 0-F (A-F shown as A b C d E F)
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational hex nibble to active-low segment pattern.
//   nibble  in  4 : hex digit 0-F
//   seg     out 7 : active-low segments, bit0=a .. bit6=g
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode display.
// Holds shadow copies of the value and decimal points, scans one digit per
// slot, blanks all anodes for a guard interval at the start of each slot, and
// optionally blanks leading zeros. All outputs are registered.
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture value/dp_in into the shadow registers
//   value          : packed hex nibbles, nibble i drives digit i (0 = rightmost)
//   dp_in          : per-digit decimal point request, active-high
//   blank_lz       : enable leading-zero blanking (digit 0 never blanked)
//   brightness     : 4-bit duty control, present only with SEVENSEG_PWM_EN
//   anodes         : digit enables, active-low
//   segments, dp_n : active-low segment and decimal point outputs
// Optional feature macro: SEVENSEG_PWM_EN (anode PWM dimming).
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned GUARD_TICKS     = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
`ifdef SEVENSEG_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   anodes,
  output seg_t                    segments,
  output logic                    dp_n
);

  localparam int unsigned TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0] GUARD_END  = TW'(GUARD_TICKS);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  logic [TW-1:0]           tick_cnt;
  logic [DW-1:0]           digit_idx;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q;

  logic [3:0]            nib;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  upper_zero;
  logic                  guard;
  logic                  blank;
  logic                  lit;
  seg_t                  glyph;

  // Mux the current digit's nibble, dp and anode pattern.
  // lz_mask[i] is set when nibble i and every higher nibble are zero;
  // built top-down so each digit inherits the state of those above it.
  always_comb begin
    nib        = '0;
    dp_sel     = 1'b0;
    an_sel     = '1;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (DW'(i) == digit_idx) begin
        nib       = val_q[4*i +: 4];
        dp_sel    = dp_q[i];
        an_sel[i] = 1'b0;
      end
    end
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (val_q[4*(NUM_DIGITS-1-k) +: 4] != 4'h0) upper_zero = 1'b0;
      lz_mask[NUM_DIGITS-1-k] = upper_zero;
    end
  end

  assign guard = (tick_cnt < GUARD_END);
  assign blank = blank_lz && (digit_idx != '0) && lz_mask[digit_idx];

  seven_seg_decode u_decode (
    .nibble (nib),
    .seg    (glyph)
  );

`ifdef SEVENSEG_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign lit = (pwm_cnt <= brightness);
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      digit_idx <= '0;
      val_q     <= '0;
      dp_q      <= '0;
      anodes    <= '1;
      segments  <= SEG_BLANK;
      dp_n      <= 1'b1;
    end else begin
      if (load) begin
        val_q <= value;
        dp_q  <= dp_in;
      end

      if (tick_cnt == TICK_LAST) begin
        tick_cnt  <= '0;
        digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + DW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      if (guard) begin
        anodes   <= '1;
        segments <= SEG_BLANK;
        dp_n     <= 1'b1;
      end else begin
        anodes   <= lit ? an_sel : '1;
        segments <= blank ? SEG_BLANK : glyph;
        dp_n     <= ~dp_sel;
      end
    end
  end

endmodule
